// File: rtl/dsram_resp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dsram_resp: data-SRAM responder, byte-lane writes, wait-stated reads.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dsram_resp #(
  parameter int ADDR_WD     = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        stall_req
);

  localparam int         DEPTH   = 1 << ADDR_WD;
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [31:0]        mem [DEPTH];
  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ADDR_WD-1:0] idx_q, idx_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic [ADDR_WD-1:0] req_idx;
  logic               accept;
  logic               is_write;
  logic               unused_addr_bits;

  // Byte offset and bits above the array depth are ignored, so addresses alias.
  assign req_idx          = data_sram_addr[ADDR_WD+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WD+2], data_sram_addr[1:0]};
  assign is_write         = |data_sram_we;
  assign accept           = data_sram_en && !flush && (state_q != S_WAIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd1) begin
          rdata_d  = mem[idx_q];
          rvalid_d = 1'b1;
          state_d  = S_RESP;
          cnt_d    = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept && !is_write) begin
          if (WAIT_CYCLES == 0) begin
            rdata_d  = mem[req_idx];
            rvalid_d = 1'b1;
            state_d  = S_RESP;
          end else begin
            idx_d   = req_idx;
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      idx_q    <= '0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array has no reset: contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[req_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata  = rdata_q;
  assign data_sram_rvalid = rvalid_q;
  assign stall_req        = (state_q == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dsram_resp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dsram_resp: scoreboard bench, zero-wait and three-wait instances.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dsram_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, fl0 = 1'b0;
  logic [3:0]  we0 = 4'h0;
  logic [31:0] a0 = '0, wd0 = '0;
  logic [31:0] rd0;
  logic        rv0, st0;

  logic        en3 = 1'b0, fl3 = 1'b0;
  logic [3:0]  we3 = 4'h0;
  logic [31:0] a3 = '0, wd3 = '0;
  logic [31:0] rd3;
  logic        rv3, st3;

  int checks = 0;
  int failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q3[$];

  dsram_resp #(.ADDR_WD(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .flush(fl0), .data_sram_en(en0),
    .data_sram_we(we0), .data_sram_addr(a0), .data_sram_wdata(wd0),
    .data_sram_rdata(rd0), .data_sram_rvalid(rv0), .stall_req(st0));

  dsram_resp #(.ADDR_WD(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst), .flush(fl3), .data_sram_en(en3),
    .data_sram_we(we3), .data_sram_addr(a3), .data_sram_wdata(wd3),
    .data_sram_rdata(rd3), .data_sram_rvalid(rv3), .stall_req(st3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data whenever a DUT presents rvalid.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (st0 !== 1'b0) begin
        failures++;
        $display("FAIL stall0_never: got %0b expected 0", st0);
      end
      if (rv0) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL rvalid0_unexpected: got rdata 0x%08h expected no rvalid", rd0);
        end else begin
          logic [31:0] e;
          e = q0.pop_front();
          if (rd0 !== e) begin
            failures++;
            $display("FAIL rdata0: got 0x%08h expected 0x%08h", rd0, e);
          end
        end
      end
      if (rv3) begin
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL rvalid3_unexpected: got rdata 0x%08h expected no rvalid", rd3);
        end else begin
          logic [31:0] e;
          e = q3.pop_front();
          if (rd3 !== e) begin
            failures++;
            $display("FAIL rdata3: got 0x%08h expected 0x%08h", rd3, e);
          end
        end
      end
    end
  end

  // One request on dut0, held for one edge.
  task automatic req0(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    en0 = 1'b1; we0 = we; a0 = a; wd0 = d;
    if (we == 4'h0) q0.push_back(exp);
    @(posedge clk); #1;
    en0 = 1'b0; we0 = 4'h0;
  endtask

  // One request on dut3; leaves the caller one time unit after the accepting edge.
  task automatic req3(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                      input bit push, input logic [31:0] exp);
    en3 = 1'b1; we3 = we; a3 = a; wd3 = d;
    if (push) q3.push_back(exp);
    @(posedge clk); #1;
    en3 = 1'b0; we3 = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("reset_rdata0",  rd0, 32'd0);
    chk("reset_rvalid0", {31'd0, rv0}, 32'd0);
    chk("reset_stall0",  {31'd0, st0}, 32'd0);
    chk("reset_rdata3",  rd3, 32'd0);
    chk("reset_rvalid3", {31'd0, rv3}, 32'd0);
    chk("reset_stall3",  {31'd0, st3}, 32'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: write/read, byte lanes, back-to-back, aliasing.
    req0(4'hF, 32'h10, 32'hDEADBEEF, 32'h0);
    req0(4'h0, 32'h10, 32'h0, 32'hDEADBEEF);
    req0(4'hF, 32'h20, 32'h11223344, 32'h0);
    req0(4'b0101, 32'h20, 32'hAABBCCDD, 32'h0);
    req0(4'h0, 32'h20, 32'h0, 32'h11BB33DD);
    idle(2);
    req0(4'h0, 32'h10, 32'h0, 32'hDEADBEEF);
    chk("b2b_rvalid_a", {31'd0, rv0}, 32'd1);
    req0(4'h0, 32'h20, 32'h0, 32'h11BB33DD);
    chk("b2b_rvalid_b", {31'd0, rv0}, 32'd1);
    req0(4'h0, 32'h10, 32'h0, 32'hDEADBEEF);
    chk("b2b_rvalid_c", {31'd0, rv0}, 32'd1);
    idle(1);
    req0(4'h0, 32'h4010, 32'h0, 32'hDEADBEEF);
    fl0 = 1'b1;
    en0 = 1'b1; we0 = 4'hF; a0 = 32'h10; wd0 = 32'h0BADF00D;
    @(posedge clk); #1;
    en0 = 1'b0; we0 = 4'h0; fl0 = 1'b0;
    req0(4'h0, 32'h10, 32'h0, 32'hDEADBEEF);
    idle(2);

    // Three wait states: stall window and single rvalid in cycle N+4.
    req3(4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    req3(4'hF, 32'h30, 32'h55AA55AA, 1'b0, 32'h0);
    req3(4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("wait_stall_c%0d", k), {31'd0, st3}, (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("wait_rvalid_c%0d", k), {31'd0, rv3}, (k == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("wait_rvalid_gone", {31'd0, rv3}, 32'd0);

    // Flush in cycle N+2 aborts the read of 0x30.
    req3(4'h0, 32'h30, 32'h0, 1'b0, 32'h0);
    chk("flush_stall_c1", {31'd0, st3}, 32'd1);
    @(posedge clk); #1;
    fl3 = 1'b1;
    chk("flush_stall_c2", {31'd0, st3}, 32'd1);
    @(posedge clk); #1;
    fl3 = 1'b0;
    chk("flush_stall_c3", {31'd0, st3}, 32'd0);
    chk("flush_rvalid_c3", {31'd0, rv3}, 32'd0);
    idle(3);
    chk("flush_rdata_kept", rd3, 32'hDEADBEEF);

    // Flush coincident with counter expiry (cycle N+3) also wins.
    req3(4'h0, 32'h30, 32'h0, 1'b0, 32'h0);
    idle(2);
    fl3 = 1'b1;
    chk("flush_exp_stall", {31'd0, st3}, 32'd1);
    @(posedge clk); #1;
    fl3 = 1'b0;
    chk("flush_exp_rvalid", {31'd0, rv3}, 32'd0);
    chk("flush_exp_stall_off", {31'd0, st3}, 32'd0);
    idle(3);

    // Asynchronous reset mid-WAIT, checked before the next edge.
    req3(4'h0, 32'h30, 32'h0, 1'b0, 32'h0);
    chk("pre_reset_stall", {31'd0, st3}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_stall", {31'd0, st3}, 32'd0);
    chk("async_rvalid", {31'd0, rv3}, 32'd0);
    chk("async_rdata", rd3, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    req3(4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    req0(4'h0, 32'h20, 32'h0, 32'h11BB33DD);
    idle(6);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
